// File: rtl/calc_pkg.sv
// calc_pkg: shared definitions for the calculator command sequencer.
//   - opcode and error-code constants
//   - FSM state encoding
//   - calc_alu: the combinational ALU shared by the sequencer
package calc_pkg;

  localparam logic [2:0] OP_PUSH = 3'd0;
  localparam logic [2:0] OP_ADD  = 3'd1;
  localparam logic [2:0] OP_SUB  = 3'd2;
  localparam logic [2:0] OP_MUL  = 3'd3;
  localparam logic [2:0] OP_AND  = 3'd4;
  localparam logic [2:0] OP_OR   = 3'd5;
  localparam logic [2:0] OP_PEEK = 3'd6;
  localparam logic [2:0] OP_DIV  = 3'd7;

  localparam logic [1:0] ERR_UNDERFLOW = 2'd0;
  localparam logic [1:0] ERR_OVERFLOW  = 2'd1;
  localparam logic [1:0] ERR_ILLEGAL   = 2'd2;
  localparam logic [1:0] ERR_DIVZ      = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PUSH,
    S_PEEK,
    S_POP1,
    S_POP2,
    S_EXEC,
    S_WB
  } calc_state_e;

  // The ALU works on ALU_W bits; callers zero-extend operands and keep the
  // low WIDTH bits, which is exact for add/sub/mul/and/or (WIDTH <= ALU_W).
  localparam int unsigned ALU_W = 64;

  function automatic logic [ALU_W-1:0] calc_alu(input logic [2:0]       op,
                                                input logic [ALU_W-1:0] a,
                                                input logic [ALU_W-1:0] b);
    logic [ALU_W-1:0] r;
    r = '0;
    case (op)
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_MUL:  r = a * b;
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/calc_sequencer_if.sv
// calc_sequencer_if: command handshake between the operator front end and
// the sequencer.
//   op_valid/op_ready/op_code/op_data : command in (accepted on valid&&ready)
//   done/err/err_code/res_data        : completion pulse, status and result
// master = front end, slave = calc_sequencer.
interface calc_sequencer_if #(
  parameter int unsigned WIDTH = 32
);
  logic             op_valid;
  logic             op_ready;
  logic [2:0]       op_code;
  logic [WIDTH-1:0] op_data;
  logic             done;
  logic             err;
  logic [1:0]       err_code;
  logic [WIDTH-1:0] res_data;

  modport master (
    output op_valid, op_code, op_data,
    input  op_ready, done, err, err_code, res_data
  );

  modport slave (
    input  op_valid, op_code, op_data,
    output op_ready, done, err, err_code, res_data
  );
endinterface

// File: rtl/calc_divider.sv
// calc_divider: unsigned restoring divider, one quotient bit per cycle.
//   clk, rst   : clock, synchronous active-high reset
//   start      : load operands; the first quotient bit is produced on the
//                same edge, so the quotient is ready WIDTH edges after start
//   dividend   : numerator (sampled with start)
//   divisor    : denominator (sampled with start)
//   busy       : iteration in progress
//   done       : 1-cycle pulse, quotient valid from this cycle until next start
//   quotient   : result
module calc_divider #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient
);
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, dvsr_q, dvsr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d, done_q, done_d;

  logic [WIDTH-1:0] src_rem, src_quo, src_dvsr, step_rem;
  logic [WIDTH:0]   shifted;
  logic             step_bit;

  always_comb begin
    src_rem  = start ? '0       : rem_q;
    src_quo  = start ? dividend : quo_q;
    src_dvsr = start ? divisor  : dvsr_q;
    shifted  = {src_rem, src_quo[WIDTH-1]};
    step_bit = (shifted >= {1'b0, src_dvsr});
    step_rem = step_bit ? WIDTH'(shifted - {1'b0, src_dvsr}) : WIDTH'(shifted);

    rem_d  = rem_q;
    quo_d  = quo_q;
    dvsr_d = dvsr_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    done_d = 1'b0;
    if (start) begin
      rem_d  = step_rem;
      quo_d  = {src_quo[WIDTH-2:0], step_bit};
      dvsr_d = divisor;
      cnt_d  = CNT_W'(WIDTH - 1);
      busy_d = 1'b1;
    end else if (busy_q) begin
      rem_d = step_rem;
      quo_d = {src_quo[WIDTH-2:0], step_bit};
      cnt_d = cnt_q - 1'b1;
      if (cnt_q == CNT_W'(1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q  <= '0;
      quo_q  <= '0;
      dvsr_q <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      dvsr_q <= dvsr_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign quotient = quo_q;
endmodule

// File: rtl/calc_sequencer.sv
// calc_sequencer: command sequencer between the operator front end and the
// stack/queue Memory. Accepts one op at a time, drives Memory push/pop,
// collects two operands for binary ops, computes and writes the result back.
// Occupancy is tracked locally so underflow/overflow are rejected before
// Memory is touched.
//   clk, rst        : clock, synchronous active-high reset (shared with Memory)
//   stack_queue     : 0 stack / 1 queue, captured while rst is high
//   op              : command handshake (calc_sequencer_if.slave)
//   occupancy       : entries currently held in Memory
//   mem_push/pop    : Memory strobes (never both high)
//   mem_stack_queue : registered mode to Memory
//   mem_data_in     : Memory write data
//   mem_stack_out   : Memory top of stack
//   mem_queue_out   : Memory queue head
// Build option: define CALC_DIV_EN to enable op 7 (unsigned DIV through
// calc_divider); otherwise op 7 is rejected as ILLEGAL.
module calc_sequencer
  import calc_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       stack_queue,
  calc_sequencer_if.slave            op,
  output logic [$clog2(DEPTH+1)-1:0] occupancy,
  output logic                       mem_push,
  output logic                       mem_pop,
  output logic                       mem_stack_queue,
  output logic [WIDTH-1:0]           mem_data_in,
  input  logic [WIDTH-1:0]           mem_stack_out,
  input  logic [WIDTH-1:0]           mem_queue_out
);
  localparam int unsigned OCC_W = $clog2(DEPTH + 1);

  calc_state_e      state_q, state_d;
  logic             mode_q;
  logic [2:0]       opc_q, opc_d;
  logic [WIDTH-1:0] x_q, x_d, y_q, y_d, res_q, res_d, wdata_q, wdata_d;
  logic             push_q, push_d, pop_q, pop_d;
  logic             ready_q, ready_d, done_q, done_d, err_q, err_d;
  logic [1:0]       ecode_q, ecode_d;
  logic [OCC_W-1:0] occ_q, occ_d;

  logic [WIDTH-1:0] rd, older, newer, alu_r, exec_r;
  logic             divz_now, pop_eff, exec_go, rej;
  logic [1:0]       rej_code;

  always_comb begin
    rd    = mode_q ? mem_queue_out : mem_stack_out;
    // Stack pops newest first, queue pops oldest first; both compute older op newer.
    older = mode_q ? x_q : y_q;
    newer = mode_q ? y_q : x_q;
    alu_r = WIDTH'(calc_alu(opc_q, ALU_W'(older), ALU_W'(newer)));
  end

`ifdef CALC_DIV_EN
  logic             div_start, div_busy, div_done;
  logic [WIDTH-1:0] div_quo;

  always_comb begin
    // The divisor (newer operand) is visible in POP1 for a stack and in POP2
    // for a queue; a zero there cancels the pop already scheduled for that cycle.
    divz_now  = (opc_q == OP_DIV) && (rd == '0) &&
                (((state_q == S_POP1) && !mode_q) || ((state_q == S_POP2) && mode_q));
    // Starting in POP2 straight from rd makes the quotient ready for WB at T+3+WIDTH.
    div_start = (state_q == S_POP2) && (opc_q == OP_DIV) && !divz_now && !div_busy;
    exec_go   = (opc_q != OP_DIV) || div_done;
    exec_r    = (opc_q == OP_DIV) ? div_quo : alu_r;
  end

  calc_divider #(.WIDTH(WIDTH)) u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start),
    .dividend (mode_q ? x_q : rd),
    .divisor  (mode_q ? rd  : x_q),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (div_quo)
  );
`else
  always_comb begin
    divz_now = 1'b0;
    exec_go  = 1'b1;
    exec_r   = alu_r;
  end
`endif

  assign pop_eff = pop_q & ~divz_now;

  always_comb begin
    state_d  = state_q;
    opc_d    = opc_q;
    x_d      = x_q;
    y_d      = y_q;
    res_d    = res_q;
    wdata_d  = wdata_q;
    ecode_d  = ecode_q;
    push_d   = 1'b0;
    pop_d    = 1'b0;
    done_d   = 1'b0;
    err_d    = 1'b0;
    rej      = 1'b0;
    rej_code = ERR_UNDERFLOW;
    occ_d    = occ_q + OCC_W'(push_q) - OCC_W'(pop_eff);

    case (state_q)
      S_IDLE: begin
        if (op.op_valid) begin
          opc_d = op.op_code;
          case (op.op_code)
            OP_PUSH: begin
              if (occ_q == OCC_W'(DEPTH)) begin
                rej      = 1'b1;
                rej_code = ERR_OVERFLOW;
              end else begin
                push_d  = 1'b1;
                wdata_d = op.op_data;
                res_d   = op.op_data;
                done_d  = 1'b1;
                state_d = S_PUSH;
              end
            end
            OP_PEEK: begin
              if (occ_q == '0) begin
                rej      = 1'b1;
                rej_code = ERR_UNDERFLOW;
              end else begin
                res_d   = rd;
                done_d  = 1'b1;
                state_d = S_PEEK;
              end
            end
`ifndef CALC_DIV_EN
            OP_DIV: begin
              rej      = 1'b1;
              rej_code = ERR_ILLEGAL;
            end
`endif
            default: begin
              if (occ_q < OCC_W'(2)) begin
                rej      = 1'b1;
                rej_code = ERR_UNDERFLOW;
              end else begin
                pop_d   = 1'b1;
                state_d = S_POP1;
              end
            end
          endcase
        end
      end
      S_PUSH, S_PEEK, S_WB: state_d = S_IDLE;
      S_POP1: begin
        x_d = rd;
        if (divz_now) begin
          rej      = 1'b1;
          rej_code = ERR_DIVZ;
          state_d  = S_IDLE;
        end else begin
          pop_d   = 1'b1;
          state_d = S_POP2;
        end
      end
      S_POP2: begin
        y_d = rd;
        if (divz_now) begin
          // Queue DIVZ: the head is already popped, so put it back at the tail.
          push_d   = 1'b1;
          wdata_d  = x_q;
          rej      = 1'b1;
          rej_code = ERR_DIVZ;
          state_d  = S_WB;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (exec_go) begin
          push_d  = 1'b1;
          wdata_d = exec_r;
          res_d   = exec_r;
          done_d  = 1'b1;
          state_d = S_WB;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (rej) begin
      done_d  = 1'b1;
      err_d   = 1'b1;
      ecode_d = rej_code;
    end
    ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      mode_q  <= stack_queue;
      opc_q   <= OP_PUSH;
      x_q     <= '0;
      y_q     <= '0;
      res_q   <= '0;
      wdata_q <= '0;
      push_q  <= 1'b0;
      pop_q   <= 1'b0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      ecode_q <= ERR_UNDERFLOW;
      occ_q   <= '0;
    end else begin
      state_q <= state_d;
      opc_q   <= opc_d;
      x_q     <= x_d;
      y_q     <= y_d;
      res_q   <= res_d;
      wdata_q <= wdata_d;
      push_q  <= push_d;
      pop_q   <= pop_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      err_q   <= err_d;
      ecode_q <= ecode_d;
      occ_q   <= occ_d;
    end
  end

  assign op.op_ready       = ready_q;
  assign op.done           = done_q;
  assign op.err            = err_q;
  assign op.err_code       = ecode_q;
  assign op.res_data       = res_q;
  assign occupancy         = occ_q;
  assign mem_push          = push_q;
  assign mem_pop           = pop_eff;
  assign mem_stack_queue   = mode_q;
  assign mem_data_in       = wdata_q;
endmodule

// File: tb/tb_calc_sequencer.sv
// tb_calc_sequencer: directed bench for calc_sequencer with a behavioural
// stack/queue Memory. Expected results are hand-computed constants.
module tb_calc_sequencer;
  import calc_pkg::*;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned DEPTH = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        stack_queue;
  logic [5:0]  occupancy;
  logic        mem_push, mem_pop, mem_stack_queue;
  logic [31:0] mem_data_in, mem_stack_out, mem_queue_out;

  always #5 clk = ~clk;

  calc_sequencer_if #(.WIDTH(WIDTH)) op_if ();

  calc_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk             (clk),
    .rst             (rst),
    .stack_queue     (stack_queue),
    .op              (op_if),
    .occupancy       (occupancy),
    .mem_push        (mem_push),
    .mem_pop         (mem_pop),
    .mem_stack_queue (mem_stack_queue),
    .mem_data_in     (mem_data_in),
    .mem_stack_out   (mem_stack_out),
    .mem_queue_out   (mem_queue_out)
  );

  int vectors = 0;
  int miscompares = 0;
  int pop_cnt = 0;
  int proto_err = 0;
  logic [31:0] mem[$];

  // Memory model: pushes go to the tail; stack pops the tail, queue the head.
  always @(posedge clk) begin
    if (rst) begin
      mem.delete();
    end else begin
      if (mem_push && mem_pop) proto_err++;
      if (mem_pop) begin
        pop_cnt++;
        if (mem.size() == 0) proto_err++;
        else if (mem_stack_queue) void'(mem.pop_front());
        else void'(mem.pop_back());
      end
      if (mem_push) begin
        if (mem.size() >= DEPTH) proto_err++;
        mem.push_back(mem_data_in);
      end
    end
    mem_stack_out <= (mem.size() > 0) ? mem[mem.size()-1] : 32'd0;
    mem_queue_out <= (mem.size() > 0) ? mem[0] : 32'd0;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issues one command and waits (bounded) for done; called at a negedge.
  task automatic run_op(input string tag, input logic [2:0] code, input logic [31:0] data,
                        input logic exp_err, input logic [1:0] exp_code,
                        input logic [31:0] exp_res, input int exp_lat, input int exp_pops);
    int p0, lat, guard;
    logic e;
    logic [1:0] ec;
    guard = 0;
    while (!op_if.op_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    op_if.op_code  = code;
    op_if.op_data  = data;
    op_if.op_valid = 1'b1;
    p0 = pop_cnt;
    @(posedge clk);
    #1 op_if.op_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!op_if.done && lat < 100);
    if (!op_if.done) check_eq({tag, " done timeout"}, 64'(op_if.done), 64'd1);
    e  = op_if.err;
    ec = op_if.err_code;
    check_eq({tag, " lat"}, 64'(lat), 64'(exp_lat));
    check_eq({tag, " err"}, 64'(e), 64'(exp_err));
    if (exp_err) check_eq({tag, " code"}, 64'(ec), 64'(exp_code));
    else check_eq({tag, " res"}, 64'(op_if.res_data), 64'(exp_res));
    @(negedge clk);
    check_eq({tag, " done pulse"}, 64'(op_if.done), 64'd0);
    check_eq({tag, " pops"}, 64'(pop_cnt - p0), 64'(exp_pops));
  endtask

  task automatic do_reset(input logic mode);
    rst = 1'b1;
    stack_queue = mode;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  int dn;

  initial begin
    rst = 1'b1;
    stack_queue = 1'b0;
    op_if.op_valid = 1'b0;
    op_if.op_code  = 3'd0;
    op_if.op_data  = 32'd0;
    repeat (2) @(negedge clk);
    check_eq("rst op_ready", 64'(op_if.op_ready), 64'd1);
    check_eq("rst done", 64'(op_if.done), 64'd0);
    check_eq("rst err", 64'(op_if.err), 64'd0);
    check_eq("rst err_code", 64'(op_if.err_code), 64'd0);
    check_eq("rst res_data", 64'(op_if.res_data), 64'd0);
    check_eq("rst occupancy", 64'(occupancy), 64'd0);
    check_eq("rst strobes", 64'({mem_push, mem_pop}), 64'd0);
    check_eq("rst mode", 64'(mem_stack_queue), 64'd0);
    rst = 1'b0;

    // Stack mode
    run_op("empty add", OP_ADD, 0, 1, ERR_UNDERFLOW, 0, 1, 0);
    run_op("empty peek", OP_PEEK, 0, 1, ERR_UNDERFLOW, 0, 1, 0);
    run_op("push 7", OP_PUSH, 7, 0, 0, 7, 1, 0);
    run_op("push 3", OP_PUSH, 3, 0, 0, 3, 1, 0);
    run_op("stk sub", OP_SUB, 0, 0, 0, 4, 4, 2);
    check_eq("stk sub occ", 64'(occupancy), 64'd1);
    check_eq("stk sub top", 64'(mem_stack_out), 64'd4);
    run_op("stk peek", OP_PEEK, 0, 0, 0, 4, 1, 0);
    run_op("add occ1", OP_ADD, 0, 1, ERR_UNDERFLOW, 0, 1, 0);
    check_eq("add occ1 res held", 64'(op_if.res_data), 64'd4);
    run_op("push ffffffff", OP_PUSH, 32'hFFFF_FFFF, 0, 0, 32'hFFFF_FFFF, 1, 0);
    run_op("add wrap", OP_ADD, 0, 0, 0, 32'd3, 4, 2);
    run_op("push 5", OP_PUSH, 5, 0, 0, 5, 1, 0);
    run_op("sub neg", OP_SUB, 0, 0, 0, 32'hFFFF_FFFE, 4, 2);
    run_op("push ff00", OP_PUSH, 32'h0000_FF00, 0, 0, 32'h0000_FF00, 1, 0);
    run_op("and", OP_AND, 0, 0, 0, 32'h0000_FF00, 4, 2);
    run_op("push 0f", OP_PUSH, 32'h0F, 0, 0, 32'h0F, 1, 0);
    run_op("or", OP_OR, 0, 0, 0, 32'h0000_FF0F, 4, 2);
    run_op("push 10000", OP_PUSH, 32'h1_0000, 0, 0, 32'h1_0000, 1, 0);
    run_op("mul", OP_MUL, 0, 0, 0, 32'hFF0F_0000, 4, 2);
    run_op("push 100", OP_PUSH, 32'h100, 0, 0, 32'h100, 1, 0);
`ifndef CALC_DIV_EN
    run_op("op7 illegal", OP_DIV, 0, 1, ERR_ILLEGAL, 0, 1, 0);
    check_eq("illegal res held", 64'(op_if.res_data), 64'h100);
    check_eq("illegal occ", 64'(occupancy), 64'd2);
`endif
    run_op("mul trunc", OP_MUL, 0, 0, 0, 32'h0F00_0000, 4, 2);
    check_eq("mul trunc occ", 64'(occupancy), 64'd1);
`ifdef CALC_DIV_EN
    run_op("push 100d", OP_PUSH, 100, 0, 0, 100, 1, 0);
    run_op("push 7d", OP_PUSH, 7, 0, 0, 7, 1, 0);
    run_op("div", OP_DIV, 0, 0, 0, 14, 35, 2);
    check_eq("div occ", 64'(occupancy), 64'd2);
    run_op("push 9", OP_PUSH, 9, 0, 0, 9, 1, 0);
    run_op("push 0", OP_PUSH, 0, 0, 0, 0, 1, 0);
    run_op("divz", OP_DIV, 0, 1, ERR_DIVZ, 0, 2, 0);
    check_eq("divz occ", 64'(occupancy), 64'd4);
`endif

    // Reset while a binary op is in POP2
    run_op("push 1", OP_PUSH, 1, 0, 0, 1, 1, 0);
    run_op("push 2", OP_PUSH, 2, 0, 0, 2, 1, 0);
    op_if.op_code  = OP_ADD;
    op_if.op_valid = 1'b1;
    @(posedge clk);
    #1 op_if.op_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_eq("midrst op_ready", 64'(op_if.op_ready), 64'd1);
    check_eq("midrst occ", 64'(occupancy), 64'd0);
    check_eq("midrst done", 64'(op_if.done), 64'd0);
    rst = 1'b0;
    dn = 0;
    repeat (6) begin
      @(negedge clk);
      if (op_if.done) dn++;
    end
    check_eq("midrst no done", 64'(dn), 64'd0);

    // Fill to capacity, then one more
    for (int i = 1; i <= 32; i++)
      run_op("fill push", OP_PUSH, 32'(i), 0, 0, 32'(i), 1, 0);
    run_op("push 33", OP_PUSH, 33, 1, ERR_OVERFLOW, 0, 1, 0);
    check_eq("full occ", 64'(occupancy), 64'd32);
    run_op("full peek", OP_PEEK, 0, 0, 0, 32, 1, 0);

    // Queue mode
    do_reset(1'b1);
    check_eq("q mode", 64'(mem_stack_queue), 64'd1);
    check_eq("q occ0", 64'(occupancy), 64'd0);
    run_op("q push 7", OP_PUSH, 7, 0, 0, 7, 1, 0);
    run_op("q push 3", OP_PUSH, 3, 0, 0, 3, 1, 0);
    run_op("q sub", OP_SUB, 0, 0, 0, 4, 4, 2);
    run_op("q push 5", OP_PUSH, 5, 0, 0, 5, 1, 0);
    run_op("q mul", OP_MUL, 0, 0, 0, 20, 4, 2);
    check_eq("q mul occ", 64'(occupancy), 64'd1);
    run_op("q peek", OP_PEEK, 0, 0, 0, 20, 1, 0);
    run_op("q push 10", OP_PUSH, 10, 0, 0, 10, 1, 0);
    run_op("q push 1", OP_PUSH, 1, 0, 0, 1, 1, 0);
    run_op("q sub order", OP_SUB, 0, 0, 0, 10, 4, 2);
    run_op("q peek head", OP_PEEK, 0, 0, 0, 1, 1, 0);
    check_eq("q occ end", 64'(occupancy), 64'd2);

    check_eq("memory protocol", 64'(proto_err), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
